// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU operation scheduler.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] OP_0 = 4'd0;
    localparam logic [3:0] OP_1 = 4'd1;
    localparam logic [3:0] OP_2 = 4'd2;
    localparam logic [3:0] OP_3 = 4'd3;

    localparam int MAX_OP_DEFAULT = 3;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, wrapping,
// and moves the pointer just past the winner when the grant is taken.
module alu_rr_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

    logic [ID_W-1:0] pointer;

    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid && req[(int'(pointer) + k) % NUM_REQ]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'((int'(pointer) + k) % NUM_REQ);
            end
        end
        if (grant_valid) grant[grant_id] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pointer <= '0;
        end else if (advance && grant_valid) begin
            pointer <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one registered ALU between NUM_REQ requesters: arbitrate, issue a single
// data_in pulse, capture the result and return it with the requester id.
module alu_op_scheduler
    import alu_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    parameter  int OP_W    = 4,
    parameter  int MAX_OP  = MAX_OP_DEFAULT,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_error,
    output logic                      alu_data_in,
    output logic [DATA_W-1:0]         alu_input_a,
    output logic [DATA_W-1:0]         alu_input_b,
    output logic [OP_W-1:0]           alu_operator,
    input  logic [DATA_W-1:0]         alu_result
);

    // Both channels are valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; the sender holds its payload until then.

    state_t             state;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_valid;
    logic [DATA_W-1:0]  win_a;
    logic [DATA_W-1:0]  win_b;
    logic [OP_W-1:0]    win_op;
    logic               win_illegal;

    // Requests are only visible to the arbiter while idle, so grants stay one-hot
    // and there is no path from rsp_ready to req_ready.
    assign arb_req   = (state == IDLE && !reset) ? req_valid : '0;
    assign req_ready = grant;

    assign win_a       = req_a[int'(grant_id) * DATA_W +: DATA_W];
    assign win_b       = req_b[int'(grant_id) * DATA_W +: DATA_W];
    assign win_op      = req_op[int'(grant_id) * OP_W +: OP_W];
    assign win_illegal = (win_op > OP_W'(MAX_OP));

    alu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arbiter (
        .clock       (clock),
        .reset       (reset),
        .req         (arb_req),
        .advance     (grant_valid),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_error    <= 1'b0;
            alu_data_in  <= 1'b0;
            alu_input_a  <= '0;
            alu_input_b  <= '0;
            alu_operator <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        alu_input_a  <= win_a;
                        alu_input_b  <= win_b;
                        alu_operator <= win_op;
                        rsp_id       <= grant_id;
                        if (win_illegal) begin
                            // Rejected without an ALU pulse; answer right away.
                            rsp_result <= '0;
                            rsp_error  <= 1'b1;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            alu_data_in <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    alu_data_in <= 1'b0;
                    state       <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_result <= alu_result;
                    rsp_error  <= 1'b0;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
